// File: rtl/exe_hazard_ctrl_if.sv
// exe_hazard_ctrl_if
//   Bundle between the EX-stage pipeline and the hazard/forwarding controller.
//   master : pipeline side; drives ID-stage decode fields, branch/busy status,
//            receives forwarding selects and stall/flush/bubble controls.
//   slave  : controller side (exe_hazard_ctrl).
//   Signals
//     id_rs, id_rt, id_rd        ID-stage register indices (REG_AW bits)
//     id_use_a/b/st              ID operand usage (ALU A, ALU B, store data)
//     id_reg_write, id_mem_read  ID destination write / load flags
//     ex_br_taken                EX instruction redirects the PC
//     mem_busy                   shared SRAM busy, whole pipe holds
//     fwd_a, fwd_b, fwd_st       registered forward selects (00 RData, 01 ALUBack, 10 WriteBackData)
//     pc_stall, ifid_stall       hold PC / IF-ID register
//     idex_bubble                load NOP into ID/EX
//     ifid_flush                 clear IF/ID
interface exe_hazard_ctrl_if #(
  parameter int REG_AW = 4
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_use_a;
  logic              id_use_b;
  logic              id_use_st;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_br_taken;
  logic              mem_busy;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [1:0]        fwd_st;
  logic              pc_stall;
  logic              ifid_stall;
  logic              idex_bubble;
  logic              ifid_flush;

  modport master (
    output id_rs, id_rt, id_rd, id_use_a, id_use_b, id_use_st,
           id_reg_write, id_mem_read, ex_br_taken, mem_busy,
    input  fwd_a, fwd_b, fwd_st, pc_stall, ifid_stall, idex_bubble, ifid_flush
  );

  modport slave (
    input  id_rs, id_rt, id_rd, id_use_a, id_use_b, id_use_st,
           id_reg_write, id_mem_read, ex_br_taken, mem_busy,
    output fwd_a, fwd_b, fwd_st, pc_stall, ifid_stall, idex_bubble, ifid_flush
  );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl
//   Hazard/forwarding scheduler for the 16-bit EX stage. A shadow EX/MEM pipe
//   of destination indices decides the registered forward selects that reach
//   EX together with the instruction, and the controller sequences load-use
//   stalls, branch/jump flushes and memory-busy freezes.
//   Ports
//     clk  system clock, rising edge
//     rst  synchronous, active-high reset
//     hz   exe_hazard_ctrl_if.slave (decode fields in, selects/controls out)
//   Parameters
//     REG_AW        register index width
//     FLUSH_CYCLES  cycles ifid_flush is asserted for one taken branch/jump (1..3),
//                   counting the cycle in which ex_br_taken is seen
//   Build option
//     FWD_ZERO_REG_EN  when defined, index 0 is hardwired zero and never forwards or stalls
//
//   state   | meaning
//   RUN     | normal issue, forwarding only
//   LDSTALL | one bubble was inserted for a load-use; ID instruction re-evaluated
//   FLUSH   | remaining wrong-path flush cycles after a taken branch/jump
//   FREEZE  | mem_busy; everything holds, saved_q remembers where to resume
module exe_hazard_ctrl #(
  parameter int REG_AW       = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  exe_hazard_ctrl_if.slave      hz
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    FREEZE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  state_t            saved_q, saved_d;
  state_t            cur;
  logic [1:0]        cnt_q, cnt_d;

  logic [REG_AW-1:0] sh_ex_rd_q, sh_ex_rd_d;
  logic              sh_ex_wr_q, sh_ex_wr_d;
  logic              sh_ex_ld_q, sh_ex_ld_d;
  logic [REG_AW-1:0] sh_mem_rd_q, sh_mem_rd_d;
  logic              sh_mem_wr_q, sh_mem_wr_d;

  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [1:0]        fwd_st_q, fwd_st_d;

  logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic              load_use;
  logic              stall, kill, bubble;

  // Destination/source index match on the full index width.
  function automatic logic idx_hit(input logic [REG_AW-1:0] rd,
                                   input logic              wr,
                                   input logic [REG_AW-1:0] src);
`ifdef FWD_ZERO_REG_EN
    return wr && (rd == src) && (rd != '0);
`else
    return wr && (rd == src);
`endif
  endfunction

  // A load still in EX has no ALU result yet, so it can only supply from MEM.
  function automatic logic [1:0] fwd_code(input logic use_it,
                                          input logic ex_hit,
                                          input logic ex_ld,
                                          input logic mem_hit);
    if (!use_it)              return 2'b00;
    else if (ex_hit && !ex_ld) return 2'b01;
    else if (mem_hit)         return 2'b10;
    else                      return 2'b00;
  endfunction

  always_comb begin
    ex_hit_rs  = idx_hit(sh_ex_rd_q,  sh_ex_wr_q,  hz.id_rs);
    ex_hit_rt  = idx_hit(sh_ex_rd_q,  sh_ex_wr_q,  hz.id_rt);
    mem_hit_rs = idx_hit(sh_mem_rd_q, sh_mem_wr_q, hz.id_rs);
    mem_hit_rt = idx_hit(sh_mem_rd_q, sh_mem_wr_q, hz.id_rt);
    load_use   = sh_ex_ld_q && ((hz.id_use_a && ex_hit_rs) ||
                                ((hz.id_use_b || hz.id_use_st) && ex_hit_rt));
  end

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    cnt_d       = cnt_q;
    sh_ex_rd_d  = sh_ex_rd_q;
    sh_ex_wr_d  = sh_ex_wr_q;
    sh_ex_ld_d  = sh_ex_ld_q;
    sh_mem_rd_d = sh_mem_rd_q;
    sh_mem_wr_d = sh_mem_wr_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    fwd_st_d    = fwd_st_q;
    stall       = 1'b0;
    kill        = 1'b0;
    bubble      = 1'b0;
    hz.pc_stall    = 1'b0;
    hz.ifid_stall  = 1'b0;
    hz.idex_bubble = 1'b0;
    hz.ifid_flush  = 1'b0;

    // While frozen, behave as the state we will resume into.
    cur = (state_q == FREEZE) ? saved_q : state_q;

    if (hz.mem_busy) begin
      hz.pc_stall   = 1'b1;
      hz.ifid_stall = 1'b1;
      state_d       = FREEZE;
      saved_d       = cur;
    end else begin
      // The taken cycle itself is the first flush cycle.
      if (hz.ex_br_taken) begin
        kill = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = 2'(FLUSH_CYCLES - 1);
        end else begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      end else if (cur == FLUSH) begin
        kill = 1'b1;
        if (cnt_q <= 2'd1) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end else begin
          state_d = FLUSH;
          cnt_d   = cnt_q - 2'd1;
        end
      end else if (load_use) begin
        stall   = 1'b1;
        state_d = LDSTALL;
      end else begin
        state_d = RUN;
      end

      bubble         = stall || kill;
      hz.pc_stall    = stall;
      hz.ifid_stall  = stall;
      hz.idex_bubble = bubble;
      hz.ifid_flush  = kill;

      sh_ex_rd_d  = hz.id_rd;
      sh_ex_wr_d  = hz.id_reg_write && !bubble;
      sh_ex_ld_d  = hz.id_mem_read && !bubble;
      sh_mem_rd_d = sh_ex_rd_q;
      sh_mem_wr_d = sh_ex_wr_q;

      if (bubble) begin
        fwd_a_d  = 2'b00;
        fwd_b_d  = 2'b00;
        fwd_st_d = 2'b00;
      end else begin
        fwd_a_d  = fwd_code(hz.id_use_a,  ex_hit_rs, sh_ex_ld_q, mem_hit_rs);
        fwd_b_d  = fwd_code(hz.id_use_b,  ex_hit_rt, sh_ex_ld_q, mem_hit_rt);
        fwd_st_d = fwd_code(hz.id_use_st, ex_hit_rt, sh_ex_ld_q, mem_hit_rt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      cnt_q       <= 2'd0;
      sh_ex_rd_q  <= '0;
      sh_ex_wr_q  <= 1'b0;
      sh_ex_ld_q  <= 1'b0;
      sh_mem_rd_q <= '0;
      sh_mem_wr_q <= 1'b0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      fwd_st_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      sh_ex_rd_q  <= sh_ex_rd_d;
      sh_ex_wr_q  <= sh_ex_wr_d;
      sh_ex_ld_q  <= sh_ex_ld_d;
      sh_mem_rd_q <= sh_mem_rd_d;
      sh_mem_wr_q <= sh_mem_wr_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      fwd_st_q    <= fwd_st_d;
    end
  end

  assign hz.fwd_a  = fwd_a_q;
  assign hz.fwd_b  = fwd_b_q;
  assign hz.fwd_st = fwd_st_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// tb_exe_hazard_ctrl
//   Self-checking bench for exe_hazard_ctrl. A reference model tracks the
//   in-flight instructions as a two-entry age array and derives forwarding,
//   stalls and flushes from the producer/consumer rules.
module tb_exe_hazard_ctrl;
  localparam int REG_AW       = 4;
  localparam int FLUSH_CYCLES = 2;

  typedef struct packed {
    logic              rst;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              use_a;
    logic              use_b;
    logic              use_st;
    logic              reg_write;
    logic              mem_read;
    logic              taken;
    logic              busy;
  } in_t;

  typedef struct {
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] rd;
  } slot_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  exe_hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

  exe_hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  // Model: m_pipe[0] is the instruction now in EX, m_pipe[1] the one in MEM.
  slot_t      m_pipe [2];
  int         m_flush_left;
  logic [1:0] m_fa, m_fb, m_fs;
  logic [9:0] e_vec;   // {fwd_a, fwd_b, fwd_st, pc_stall, ifid_stall, idex_bubble, ifid_flush}

  function automatic logic zero_blocked(input logic [REG_AW-1:0] src);
`ifdef FWD_ZERO_REG_EN
    return src == '0;
`else
    return 1'b0;
`endif
  endfunction

  // Youngest in-flight producer of src decides the source; a load in EX cannot supply.
  function automatic logic [1:0] src_code(input logic [REG_AW-1:0] src, input logic used);
    if (!used || zero_blocked(src)) return 2'b00;
    for (int age = 0; age < 2; age++) begin
      if (m_pipe[age].wr && m_pipe[age].rd == src) begin
        if (age == 0 && !m_pipe[0].ld) return 2'b01;
        if (age == 1) return 2'b10;
      end
    end
    return 2'b00;
  endfunction

  function automatic logic needs_load_in_ex(input logic [REG_AW-1:0] src, input logic used);
    return used && !zero_blocked(src) && m_pipe[0].wr && m_pipe[0].ld && m_pipe[0].rd == src;
  endfunction

  function automatic logic [9:0] obs_vec();
    return {hz.fwd_a, hz.fwd_b, hz.fwd_st, hz.pc_stall, hz.ifid_stall, hz.idex_bubble, hz.ifid_flush};
  endfunction

  function automatic in_t instr(input int rs_i, input int rt_i, input int rd_i,
                                input logic ua, input logic ub, input logic us,
                                input logic wr, input logic ld);
    in_t s;
    s           = '0;
    s.rs        = REG_AW'(rs_i);
    s.rt        = REG_AW'(rt_i);
    s.rd        = REG_AW'(rd_i);
    s.use_a     = ua;
    s.use_b     = ub;
    s.use_st    = us;
    s.reg_write = wr;
    s.mem_read  = ld;
    return s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) m_pipe[i] = '{wr: 1'b0, ld: 1'b0, rd: '0};
    m_flush_left = 0;
    m_fa = 2'b00;
    m_fb = 2'b00;
    m_fs = 2'b00;
  endtask

  // Drive one cycle at the falling edge, then work out what the DUT must show now.
  task automatic step(input in_t s);
    logic       stall, fl, bub;
    logic [1:0] n_fa, n_fb, n_fs;
    @(negedge clk);
    rst             = s.rst;
    hz.id_rs        = s.rs;
    hz.id_rt        = s.rt;
    hz.id_rd        = s.rd;
    hz.id_use_a     = s.use_a;
    hz.id_use_b     = s.use_b;
    hz.id_use_st    = s.use_st;
    hz.id_reg_write = s.reg_write;
    hz.id_mem_read  = s.mem_read;
    hz.ex_br_taken  = s.taken;
    hz.mem_busy     = s.busy;
    #1;
    stall = 1'b0;
    fl    = 1'b0;
    e_vec = {m_fa, m_fb, m_fs, 4'b0000};
    if (s.rst) begin
      m_reset();
    end else if (s.busy) begin
      e_vec[3:2] = 2'b11;
    end else begin
      if (s.taken) begin
        fl = 1'b1;
        m_flush_left = FLUSH_CYCLES - 1;
      end else if (m_flush_left > 0) begin
        fl = 1'b1;
        m_flush_left--;
      end else if (needs_load_in_ex(s.rs, s.use_a) || needs_load_in_ex(s.rt, s.use_b || s.use_st)) begin
        stall = 1'b1;
      end
      bub        = stall || fl;
      e_vec[3:0] = {stall, stall, bub, fl};
      n_fa = bub ? 2'b00 : src_code(s.rs, s.use_a);
      n_fb = bub ? 2'b00 : src_code(s.rt, s.use_b);
      n_fs = bub ? 2'b00 : src_code(s.rt, s.use_st);
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = '{wr: s.reg_write && !bub, ld: s.mem_read && !bub, rd: s.rd};
      m_fa = n_fa;
      m_fb = n_fb;
      m_fs = n_fs;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(instr(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    in_t s;
    s = instr(0, 0, 0, 0, 0, 0, 0, 0);
    s.rst = 1'b1;
    step(s);
    step(s);
    idle(1);
    n_tests++;
    if (obs_vec() !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs_vec(), 10'b0);
    end
  endtask

  task automatic test_fwd_ex();
    idle(2);
    step(instr(0, 0, 1, 0, 0, 0, 1, 0));       // ADD r1
    step(instr(1, 3, 2, 1, 1, 0, 1, 0));       // ADD r2,r1,r3
    n_tests++;
    if (hz.pc_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_ex_nostall: got pc_stall=%b expected 0", hz.pc_stall);
    end
    idle(1);
    n_tests++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'b01_00) begin
      n_fail++;
      $display("FAIL fwd_ex_sel: got a=%b b=%b expected a=01 b=00", hz.fwd_a, hz.fwd_b);
    end
  endtask

  task automatic test_fwd_mem();
    idle(2);
    step(instr(0, 0, 1, 0, 0, 0, 1, 0));       // ADD r1
    idle(1);                                    // NOP
    step(instr(1, 1, 4, 1, 1, 0, 1, 0));       // SUB r4,r1,r1
    n_tests++;
    if (hz.pc_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_mem_nostall: got pc_stall=%b expected 0", hz.pc_stall);
    end
    idle(1);
    n_tests++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'b10_10) begin
      n_fail++;
      $display("FAIL fwd_mem_sel: got a=%b b=%b expected a=10 b=10", hz.fwd_a, hz.fwd_b);
    end
  endtask

  task automatic test_load_use();
    idle(2);
    step(instr(0, 0, 2, 0, 0, 0, 1, 1));       // LW r2
    step(instr(2, 6, 5, 1, 1, 0, 1, 0));       // ADD r5,r2,r6
    n_tests++;
    if (obs_vec() !== 10'b00_00_00_1110) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b expected %b", obs_vec(), 10'b00_00_00_1110);
    end
    step(instr(2, 6, 5, 1, 1, 0, 1, 0));       // held ADD re-evaluated
    n_tests++;
    if (obs_vec() !== 10'b0) begin
      n_fail++;
      $display("FAIL load_use_release: got %b expected %b", obs_vec(), 10'b0);
    end
    idle(1);
    n_tests++;
    if ({hz.fwd_a, hz.fwd_b} !== 4'b10_00) begin
      n_fail++;
      $display("FAIL load_use_fwd: got a=%b b=%b expected a=10 b=00", hz.fwd_a, hz.fwd_b);
    end
  endtask

  task automatic test_store_after_load();
    idle(2);
    step(instr(0, 0, 3, 0, 0, 0, 1, 1));       // LW r3
    step(instr(4, 3, 0, 1, 0, 1, 0, 0));       // SW r3,(r4)
    n_tests++;
    if (obs_vec() !== 10'b00_00_00_1110) begin
      n_fail++;
      $display("FAIL store_load_stall: got %b expected %b", obs_vec(), 10'b00_00_00_1110);
    end
    step(instr(4, 3, 0, 1, 0, 1, 0, 0));
    idle(1);
    n_tests++;
    if ({hz.fwd_a, hz.fwd_st} !== 4'b00_10) begin
      n_fail++;
      $display("FAIL store_load_fwd: got a=%b st=%b expected a=00 st=10", hz.fwd_a, hz.fwd_st);
    end
  endtask

  task automatic test_branch_over_load_use();
    in_t s;
    idle(2);
    step(instr(0, 0, 2, 0, 0, 0, 1, 1));       // LW r2
    s = instr(2, 6, 5, 1, 1, 0, 1, 0);
    s.taken = 1'b1;
    step(s);
    n_tests++;
    if (obs_vec() !== 10'b00_00_00_0011) begin
      n_fail++;
      $display("FAIL branch_flush_first: got %b expected %b", obs_vec(), 10'b00_00_00_0011);
    end
    for (int i = 1; i < FLUSH_CYCLES; i++) begin
      idle(1);
      n_tests++;
      if (obs_vec() !== 10'b00_00_00_0011) begin
        n_fail++;
        $display("FAIL branch_flush_hold: got %b expected %b", obs_vec(), 10'b00_00_00_0011);
      end
    end
    idle(1);
    n_tests++;
    if (obs_vec() !== 10'b0) begin
      n_fail++;
      $display("FAIL branch_flush_end: got %b expected %b", obs_vec(), 10'b0);
    end
  endtask

  task automatic test_flush_restart();
    in_t t;
    logic exp_fl [5];
    idle(2);
    t = instr(0, 0, 0, 0, 0, 0, 0, 0);
    t.taken = 1'b1;
    // taken, idle, taken again, then the restarted FLUSH_CYCLES=2 window
    exp_fl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 2) step(t);
      else idle(1);
      n_tests++;
      if (hz.ifid_flush !== exp_fl[i]) begin
        n_fail++;
        $display("FAIL flush_restart[%0d]: got %b expected %b", i, hz.ifid_flush, exp_fl[i]);
      end
    end
  endtask

  task automatic test_freeze();
    in_t s;
    idle(2);
    step(instr(0, 0, 2, 0, 0, 0, 1, 1));       // LW r2
    step(instr(2, 6, 5, 1, 1, 0, 1, 0));       // load-use stall
    s = instr(2, 6, 5, 1, 1, 0, 1, 0);
    s.busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(s);
      n_tests++;
      if (obs_vec() !== 10'b00_00_00_1100) begin
        n_fail++;
        $display("FAIL freeze[%0d]: got %b expected %b", i, obs_vec(), 10'b00_00_00_1100);
      end
    end
    step(instr(2, 6, 5, 1, 1, 0, 1, 0));
    n_tests++;
    if (obs_vec() !== 10'b0) begin
      n_fail++;
      $display("FAIL freeze_release: got %b expected %b", obs_vec(), 10'b0);
    end
    idle(1);
    n_tests++;
    if (hz.fwd_a !== 2'b10) begin
      n_fail++;
      $display("FAIL freeze_fwd: got a=%b expected 10", hz.fwd_a);
    end
  endtask

  task automatic test_zero_reg();
    logic [3:0] exp_ab;
`ifdef FWD_ZERO_REG_EN
    exp_ab = 4'b00_00;
`else
    exp_ab = 4'b01_01;
`endif
    idle(2);
    step(instr(0, 0, 0, 1, 0, 0, 1, 0));       // ADDI r0
    step(instr(0, 0, 1, 1, 1, 0, 1, 0));       // ADD r1,r0,r0
    idle(1);
    n_tests++;
    if ({hz.fwd_a, hz.fwd_b} !== exp_ab) begin
      n_fail++;
      $display("FAIL zero_reg: got %b expected %b", {hz.fwd_a, hz.fwd_b}, exp_ab);
    end
  endtask

  task automatic test_reset_mid();
    in_t s;
    idle(2);
    s = instr(0, 0, 0, 0, 0, 0, 0, 0);
    s.taken = 1'b1;
    step(s);
    s = instr(0, 0, 0, 0, 0, 0, 0, 0);
    s.rst = 1'b1;
    step(s);
    idle(1);
    n_tests++;
    if (obs_vec() !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got %b expected %b", obs_vec(), 10'b0);
    end
    step(instr(0, 0, 2, 0, 0, 0, 1, 1));       // LW r2
    s = instr(2, 2, 5, 1, 1, 0, 1, 0);
    s.rst = 1'b1;
    step(s);
    step(instr(2, 2, 5, 1, 1, 0, 1, 0));
    n_tests++;
    if (obs_vec() !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_stall: got %b expected %b", obs_vec(), 10'b0);
    end
  endtask

  task automatic test_random();
    in_t s;
    for (int i = 0; i < 600; i++) begin
      s           = '0;
      s.rst       = ($urandom_range(0, 99) == 0);
      s.rs        = REG_AW'($urandom_range(0, 3));
      s.rt        = REG_AW'($urandom_range(0, 3));
      s.rd        = REG_AW'($urandom_range(0, 3));
      s.use_a     = 1'($urandom_range(0, 1));
      s.use_b     = 1'($urandom_range(0, 1));
      s.use_st    = ($urandom_range(0, 3) == 0);
      s.reg_write = ($urandom_range(0, 3) != 0);
      s.mem_read  = ($urandom_range(0, 2) == 0);
      s.taken     = ($urandom_range(0, 9) == 0);
      s.busy      = ($urandom_range(0, 7) == 0);
      step(s);
      if (!s.rst) begin
        n_tests++;
        if (obs_vec() !== e_vec) begin
          n_fail++;
          $display("FAIL random[%0d]: got %b expected %b", i, obs_vec(), e_vec);
        end
      end
    end
  endtask

  initial begin
    m_reset();
    rst             = 1'b1;
    hz.id_rs        = '0;
    hz.id_rt        = '0;
    hz.id_rd        = '0;
    hz.id_use_a     = 1'b0;
    hz.id_use_b     = 1'b0;
    hz.id_use_st    = 1'b0;
    hz.id_reg_write = 1'b0;
    hz.id_mem_read  = 1'b0;
    hz.ex_br_taken  = 1'b0;
    hz.mem_busy     = 1'b0;
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_store_after_load();
    test_branch_over_load_use();
    test_flush_restart();
    test_freeze();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
